// File: rtl/nlms_ctrlport_regs.sv
// CtrlPort responder for the NLMS block: config registers, sample counter, indirect coefficient access.
// Latency: register hits ack 1 cycle after the request; COEF_DATA acks 1 cycle after coef_ack or after TIMEOUT cycles.
// Backpressure: none on CtrlPort; requests arriving while a coefficient access is outstanding are dropped unacked.
//
// Ports:
//   ctrlport_clk / ctrlport_rst      sole clock, synchronous active-high reset
//   s_ctrlport_req_* / resp_*        CtrlPort responder (one-cycle wr/rd strobes, one-cycle ack)
//   enable, mu, num_taps             filter configuration to the NLMS datapath
//   coef_clear                       one-cycle pulse zeroing all coefficients
//   coef_req/we/idx/wdata, coef_ack/rdata   level request / pulse ack handshake to coefficient memory
//   sample_inc                       one pulse per output sample, counted in SAMPLE_CNT
module nlms_ctrlport_regs #(
    parameter logic [19:0] BASE_ADDR    = 20'h00000,
    parameter int          NUM_TAPS_MAX = 32,
    parameter int          COEF_W       = 16,
    parameter int          TIMEOUT      = 64
) (
    input  logic                              ctrlport_clk,
    input  logic                              ctrlport_rst,
    input  logic                              s_ctrlport_req_wr,
    input  logic                              s_ctrlport_req_rd,
    input  logic [19:0]                       s_ctrlport_req_addr,
    input  logic [31:0]                       s_ctrlport_req_data,
    output logic                              s_ctrlport_resp_ack,
    output logic [31:0]                       s_ctrlport_resp_data,
    output logic                              enable,
    output logic [15:0]                       mu,
    output logic [$clog2(NUM_TAPS_MAX):0]     num_taps,
    output logic                              coef_clear,
    output logic                              coef_req,
    output logic                              coef_we,
    output logic [$clog2(NUM_TAPS_MAX)-1:0]   coef_idx,
    output logic [COEF_W-1:0]                 coef_wdata,
    input  logic                              coef_ack,
    input  logic [COEF_W-1:0]                 coef_rdata,
    input  logic                              sample_inc
);

    localparam int IDX_W = $clog2(NUM_TAPS_MAX);
    localparam int NT_W  = IDX_W + 1;
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    localparam logic [2:0] OFF_COMPAT   = 3'd0;
    localparam logic [2:0] OFF_CTRL     = 3'd1;
    localparam logic [2:0] OFF_MU       = 3'd2;
    localparam logic [2:0] OFF_NUM_TAPS = 3'd3;
    localparam logic [2:0] OFF_COEF_IDX = 3'd4;
    localparam logic [2:0] OFF_COEF_DAT = 3'd5;
    localparam logic [2:0] OFF_SAMP_CNT = 3'd6;

    localparam logic [31:0] COMPAT_VAL  = 32'h0001_0000;
    localparam logic [31:0] TIMEOUT_VAL = 32'hDEAD_C0EF;

    typedef enum logic {
        ST_IDLE,
        ST_COEF_WAIT
    } state_t;

    state_t              state_q;
    logic                ack_q;
    logic [31:0]         resp_data_q;
    logic                enable_q;
    logic [15:0]         mu_q;
    logic [NT_W-1:0]     num_taps_q;
    logic [IDX_W-1:0]    coef_idx_q;
    logic                coef_clear_q;
    logic                coef_req_q;
    logic                coef_we_q;
    logic [COEF_W-1:0]   coef_wdata_q;
    logic                timeout_flag_q;
    logic [31:0]         sample_cnt_q;
    logic [TO_W-1:0]     to_cnt_q;

    logic                hit;
    logic                is_wr;
    logic [2:0]          offset;
    logic [31:0]         rd_data_d;
    logic [NT_W-1:0]     num_taps_d;

    // Byte-lane bits carry no meaning for 32-bit registers.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^s_ctrlport_req_addr[1:0];

    // Misses stay silent so other responders may share the bus; wr+rd counts as a write.
    assign hit    = (s_ctrlport_req_wr || s_ctrlport_req_rd) &&
                    (s_ctrlport_req_addr[19:5] == BASE_ADDR[19:5]);
    assign is_wr  = s_ctrlport_req_wr;
    assign offset = s_ctrlport_req_addr[4:2];

    always_comb begin
        rd_data_d = 32'h0;
        case (offset)
            OFF_COMPAT:   rd_data_d = COMPAT_VAL;
            OFF_CTRL:     rd_data_d = {23'h0, timeout_flag_q, 7'h0, enable_q};
            OFF_MU:       rd_data_d = {16'h0, mu_q};
            OFF_NUM_TAPS: rd_data_d = 32'(num_taps_q);
            OFF_COEF_IDX: rd_data_d = 32'(coef_idx_q);
            OFF_SAMP_CNT: rd_data_d = sample_cnt_q;
            default:      rd_data_d = 32'h0;
        endcase
    end

    // Tap count is clamped into 1..NUM_TAPS_MAX so the datapath never sees an illegal value.
    always_comb begin
        num_taps_d = s_ctrlport_req_data[NT_W-1:0];
        if (s_ctrlport_req_data == 32'h0) begin
            num_taps_d = NT_W'(1);
        end else if (s_ctrlport_req_data > 32'(NUM_TAPS_MAX)) begin
            num_taps_d = NT_W'(NUM_TAPS_MAX);
        end
    end

    always_ff @(posedge ctrlport_clk) begin
        if (ctrlport_rst) begin
            state_q        <= ST_IDLE;
            ack_q          <= 1'b0;
            resp_data_q    <= 32'h0;
            enable_q       <= 1'b0;
            mu_q           <= 16'h0100;
            num_taps_q     <= NT_W'(NUM_TAPS_MAX);
            coef_idx_q     <= '0;
            coef_clear_q   <= 1'b0;
            coef_req_q     <= 1'b0;
            coef_we_q      <= 1'b0;
            coef_wdata_q   <= '0;
            timeout_flag_q <= 1'b0;
            sample_cnt_q   <= 32'h0;
            to_cnt_q       <= '0;
        end else begin
            ack_q        <= 1'b0;
            resp_data_q  <= 32'h0;
            coef_clear_q <= 1'b0;

            if (sample_inc) begin
                sample_cnt_q <= sample_cnt_q + 32'd1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (hit && offset == OFF_COEF_DAT) begin
                        // Launch the coefficient access; ack is deferred until the core answers.
                        coef_req_q <= 1'b1;
                        coef_we_q  <= is_wr;
                        if (is_wr) begin
                            coef_wdata_q <= s_ctrlport_req_data[COEF_W-1:0];
                        end
                        to_cnt_q   <= '0;
                        state_q    <= ST_COEF_WAIT;
                    end else if (hit) begin
                        ack_q       <= 1'b1;
                        resp_data_q <= is_wr ? 32'h0 : rd_data_d;
                        if (is_wr) begin
                            case (offset)
                                OFF_CTRL: begin
                                    enable_q <= s_ctrlport_req_data[0];
                                    if (s_ctrlport_req_data[1]) begin
                                        coef_clear_q <= 1'b1;
                                    end
                                    if (s_ctrlport_req_data[8]) begin
                                        timeout_flag_q <= 1'b0;
                                    end
                                end
                                OFF_MU:       mu_q       <= s_ctrlport_req_data[15:0];
                                OFF_NUM_TAPS: num_taps_q <= num_taps_d;
                                OFF_COEF_IDX: coef_idx_q <= s_ctrlport_req_data[IDX_W-1:0];
                                // Placed after the increment so a coincident sample_inc loses.
                                OFF_SAMP_CNT: sample_cnt_q <= 32'h0;
                                default: ;
                            endcase
                        end
                    end
                end
                ST_COEF_WAIT: begin
                    if (coef_ack) begin
                        coef_req_q  <= 1'b0;
                        ack_q       <= 1'b1;
                        resp_data_q <= coef_we_q ? 32'h0 : 32'(coef_rdata);
                        state_q     <= ST_IDLE;
                    end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                        // coef_req has been high TIMEOUT cycles: give up and flag it.
                        coef_req_q     <= 1'b0;
                        ack_q          <= 1'b1;
                        resp_data_q    <= TIMEOUT_VAL;
                        timeout_flag_q <= 1'b1;
                        state_q        <= ST_IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign s_ctrlport_resp_ack  = ack_q;
    assign s_ctrlport_resp_data = resp_data_q;
    assign enable               = enable_q;
    assign mu                   = mu_q;
    assign num_taps             = num_taps_q;
    assign coef_clear           = coef_clear_q;
    assign coef_req             = coef_req_q;
    assign coef_we              = coef_we_q;
    assign coef_idx             = coef_idx_q;
    assign coef_wdata           = coef_wdata_q;

endmodule

// File: doc/nlms_ctrlport_regs.md
Name: nlms_ctrlport_regs

Overview:
- CtrlPort responder for the NLMS block. It is the other end of the CtrlPort master that noc_shell_nlms drives on ctrlport_clk.
- Holds the filter configuration registers (enable, step size mu, tap count) and a sample counter.
- Provides indirect access to coefficients through a req/ack handshake to the NLMS core's coefficient memory.
- Sits between noc_shell_nlms and the NLMS datapath inside rfnoc_block_nlms.

Parameters:
- BASE_ADDR, 20'h00000: byte base of the 32-byte register window; must be 32-byte aligned.
- NUM_TAPS_MAX, 32: maximum tap count; power of 2, range 2..256.
- COEF_W, 16: coefficient width in bits, range 1..32.
- TIMEOUT, 64: maximum cycles to wait for coef_ack before forced completion.

Ports:
- ctrlport_clk  in  1  sole clock.
- ctrlport_rst  in  1  synchronous, active-high reset.
- s_ctrlport_req_wr  in  1  write strobe, one cycle.
- s_ctrlport_req_rd  in  1  read strobe, one cycle.
- s_ctrlport_req_addr  in  20  byte address.
- s_ctrlport_req_data  in  32  write data.
- s_ctrlport_resp_ack  out  1  response strobe, one cycle.
- s_ctrlport_resp_data  out  32  read data; valid only while ack=1, 0 otherwise.
- enable  out  1  filter enable.
- mu  out  16  step size, unsigned Q1.15.
- num_taps  out  $clog2(NUM_TAPS_MAX)+1  active tap count.
- coef_clear  out  1  one-cycle pulse that zeroes all coefficients.
- coef_req  out  1  coefficient access request; level, held until coef_ack or timeout.
- coef_we  out  1  1 = write, 0 = read; stable while coef_req=1.
- coef_idx  out  $clog2(NUM_TAPS_MAX)  tap index; stable while coef_req=1.
- coef_wdata  out  COEF_W  coefficient write data; stable while coef_req=1.
- coef_ack  in  1  core completion, one cycle.
- coef_rdata  in  COEF_W  read data; valid with coef_ack.
- sample_inc  in  1  one pulse per output sample produced by the core.

Behaviour:
- Decode: a request hits when addr[19:5]==BASE_ADDR[19:5]. Word offset is addr[4:2]; addr[1:0] are ignored. A miss produces no ack, so other responders may share the bus. wr and rd asserted together are treated as a write.
- Register map (word offset: register):
  - 0 COMPAT: RO, 32'h0001_0000.
  - 1 CTRL:
    - bit0 enable, RW.
    - bit1 coef_clear, write-1 pulse, reads 0.
    - bit8 coef_timeout, sticky; set on timeout; write 1 clears.
    - Other bits read 0.
  - 2 MU: RW [15:0], upper bits read 0.
  - 3 NUM_TAPS: RW. A write of 0 stores 1. A write greater than NUM_TAPS_MAX stores NUM_TAPS_MAX.
  - 4 COEF_IDX: RW, low $clog2(NUM_TAPS_MAX) bits, upper bits read 0.
  - 5 COEF_DATA:
    - Write launches a coefficient write at COEF_IDX with data[COEF_W-1:0].
    - Read launches a coefficient read; the response is coef_rdata zero-extended.
  - 6 SAMPLE_CNT: 32-bit count of sample_inc pulses, wraps 0xFFFFFFFF -> 0. Any write clears it.
  - 7: reserved, reads 0, writes ignored, still acked.
- Reset values:
  - ack=0, resp_data=0, enable=0.
  - mu=16'h0100, num_taps=NUM_TAPS_MAX, COEF_IDX=0.
  - coef_clear=0, coef_req=0, coef_we=0, coef_wdata=0.
  - SAMPLE_CNT=0, coef_timeout=0, FSM=IDLE.
- FSM states IDLE and COEF_WAIT.
  - IDLE, hit on offsets 0-4, 6 or 7: the register updates and ack asserts exactly 1 cycle after the request.
  - IDLE, hit on offset 5: the next cycle coef_req=1 with idx/we/wdata latched; go to COEF_WAIT and load the timeout counter to 0.
  - COEF_WAIT, coef_ack=1: drop coef_req the next cycle and ack in that same cycle. On a read, resp_data = coef_rdata captured at coef_ack.
  - COEF_WAIT, TIMEOUT cycles elapsed with no coef_ack: drop coef_req, ack with resp_data=32'hDEAD_C0EF, set coef_timeout, return to IDLE.
  - COEF_WAIT, new CtrlPort requests: dropped, with no ack and no side effects.
- coef_clear pulses exactly 1 cycle, on the cycle ack asserts for the CTRL write. Writing enable and coef_clear together is legal.
- sample_inc and a SAMPLE_CNT write in the same cycle: the clear wins and the count becomes 0.
- Reset during COEF_WAIT: coef_req=0 the next cycle and no ack is emitted. A late coef_ack is ignored.
- coef_ack while in IDLE is ignored.

Test Plan:
- Reset, then read offsets 0, 2, 3 (NUM_TAPS_MAX=32) -> ack 1 cycle after each request; data 0x00010000, 0x00000100, 0x00000020.
- Write NUM_TAPS=0 then read it -> 1. Write 100 then read -> 32. Write mu=0x1234_ABCD then read MU -> 0x0000ABCD.
- Write COEF_IDX=5, then write COEF_DATA=0x7FFF; core acks after 3 cycles -> coef_req high 3 cycles with idx=5, we=1, wdata=0x7FFF; CtrlPort ack 1 cycle after coef_ack.
- Read COEF_DATA with the core silent, TIMEOUT=64 -> ack at cycle 65 with data 0xDEADC0EF; CTRL reads 0x100; write CTRL=0x100 -> CTRL reads 0.
- Write CTRL=0x3 -> enable=1 and a single-cycle coef_clear; CTRL reads 0x1.
- 10 sample_inc pulses, then a SAMPLE_CNT write coincident with an 11th pulse -> count 0. Also issue a read at BASE_ADDR+0x40 -> no ack.
